// File: rtl/lmi_iram_rsp_if.sv
// Request/response and RAM-side bus of the instruction-RAM responder.
// The slave modport is the responder; the master modport is the requester together with the RAM model.
interface lmi_iram_rsp_if #(
  parameter int BASE_LO = 11,
  parameter int TOP_HI  = 15
);
  logic                 req;
  logic                 rd;
  logic                 wr;
  logic [31:0]          addr;
  logic [3:0]           be;
  logic [31:0]          wdata;
  logic [31:BASE_LO]    base;
  logic [TOP_HI:4]      top;
  logic [31:0]          rdata;
  logic                 ack;
  logic                 miss;
  logic                 busy;
  logic                 ram_cs;
  logic [3:0]           ram_we;
  logic [TOP_HI-2:0]    ram_addr;
  logic [31:0]          ram_wdata;
  logic [31:0]          ram_rdata;

  modport slave (
    input  req, rd, wr, addr, be, wdata, base, top, ram_rdata,
    output rdata, ack, miss, busy, ram_cs, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req, rd, wr, addr, be, wdata, base, top, ram_rdata,
    input  rdata, ack, miss, busy, ram_cs, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/lmi_iram_rsp.sv
// Single-port instruction RAM responder: address-window decode, one RAM access per request,
// programmable wait states, and one-cycle ACK/MISS strobes.
module lmi_iram_rsp #(
  parameter int BASE_LO     = 11,
  parameter int TOP_HI      = 15,
  parameter int WAIT_STATES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  lmi_iram_rsp_if.slave        bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_cnt, w_cnt_nxt;
  logic                r_is_wr;
  logic                r_ack, r_miss, r_ram_cs;
  logic [3:0]          r_ram_we;
  logic [31:0]         r_rdata, r_ram_wdata;
  logic [TOP_HI-2:0]   r_ram_addr;

  logic                w_hit, w_one_dir, w_both, w_accept, w_reject;
  logic                w_ack_nxt, w_miss_nxt, w_cs_nxt, w_rdata_ld;
  logic [3:0]          w_we_nxt;

  // Window: same upper segment, at/above BASE inside the segment, at/below TOP (16-byte granule).
  assign w_hit = (bus.addr[31:TOP_HI+1] == bus.base[31:TOP_HI+1]) &&
                 (bus.addr[TOP_HI:BASE_LO] >= bus.base[TOP_HI:BASE_LO]) &&
                 (bus.addr[TOP_HI:4] <= bus.top);

  assign w_one_dir = bus.rd ^ bus.wr;
  assign w_both    = bus.rd & bus.wr;
  assign w_accept  = (r_state == S_IDLE) && bus.req && w_one_dir && w_hit;
  assign w_reject  = (r_state == S_IDLE) && bus.req && (w_both || (w_one_dir && !w_hit));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (WAIT_STATES > 0) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 3'(WAIT_STATES - 1);
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd0) w_state_nxt = S_RESP;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered strobes, keyed off the state being entered
  always_comb begin
    w_cs_nxt   = (w_state_nxt == S_ACCESS);
    w_we_nxt   = (w_cs_nxt && bus.wr) ? bus.be : 4'b0000;
    w_ack_nxt  = (w_state_nxt == S_RESP);
    w_miss_nxt = w_reject;
    w_rdata_ld = (w_state_nxt == S_RESP) && !r_is_wr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack       <= 1'b0;
      r_miss      <= 1'b0;
      r_ram_cs    <= 1'b0;
      r_ram_we    <= 4'b0000;
      r_rdata     <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_is_wr     <= 1'b0;
    end else begin
      r_ack    <= w_ack_nxt;
      r_miss   <= w_miss_nxt;
      r_ram_cs <= w_cs_nxt;
      r_ram_we <= w_we_nxt;
      if (w_accept) begin
        r_ram_addr  <= bus.addr[TOP_HI:2];
        r_ram_wdata <= bus.wdata;
        r_is_wr     <= bus.wr;
      end
      if (w_rdata_ld) r_rdata <= bus.ram_rdata;
    end
  end

  assign bus.ack       = r_ack;
  assign bus.miss      = r_miss;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.ram_cs    = r_ram_cs;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.rdata     = r_rdata;

endmodule

// File: tb/tb_lmi_iram_rsp.sv
// Directed bench: one responder with one wait state and one with none, sharing clock and reset.
module tb_lmi_iram_rsp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lmi_iram_rsp_if #(.BASE_LO(11), .TOP_HI(15)) b1 ();
  lmi_iram_rsp_if #(.BASE_LO(11), .TOP_HI(15)) b0 ();

  lmi_iram_rsp #(.BASE_LO(11), .TOP_HI(15), .WAIT_STATES(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b1));
  lmi_iram_rsp #(.BASE_LO(11), .TOP_HI(15), .WAIT_STATES(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b0));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (b1.ack !== 1'b0 || b1.miss !== 1'b0 || b1.busy !== 1'b0) begin errors++; $display("FAIL reset_strobes got ack=%b miss=%b busy=%b exp 0 0 0", b1.ack, b1.miss, b1.busy); end
    checks++; if (b1.ram_cs !== 1'b0 || b1.ram_we !== 4'h0) begin errors++; $display("FAIL reset_ram got cs=%b we=%h exp 0 0", b1.ram_cs, b1.ram_we); end
    checks++; if (b1.rdata !== 32'h0 || b1.ram_addr !== 14'h0 || b1.ram_wdata !== 32'h0) begin errors++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h exp 0", b1.rdata, b1.ram_addr, b1.ram_wdata); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_read();
    b1.req = 1'b1; b1.rd = 1'b1; b1.wr = 1'b0; b1.addr = 32'h1FC00010;
    tick();  // cycle 1
    b1.req = 1'b0;
    checks++; if (b1.ram_cs !== 1'b1 || b1.ram_addr !== 14'h0004 || b1.ram_we !== 4'h0) begin errors++; $display("FAIL rd_c1 got cs=%b addr=%h we=%h exp 1 0004 0", b1.ram_cs, b1.ram_addr, b1.ram_we); end
    checks++; if (b1.busy !== 1'b1) begin errors++; $display("FAIL rd_busy got %b exp 1", b1.busy); end
    tick();  // cycle 2
    checks++; if (b1.ram_cs !== 1'b0 || b1.ack !== 1'b0) begin errors++; $display("FAIL rd_c2 got cs=%b ack=%b exp 0 0", b1.ram_cs, b1.ack); end
    tick();  // cycle 3
    checks++; if (b1.ack !== 1'b1 || b1.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_c3 got ack=%b rdata=%h exp 1 deadbeef", b1.ack, b1.rdata); end
    tick();
    checks++; if (b1.ack !== 1'b0 || b1.busy !== 1'b0) begin errors++; $display("FAIL rd_c4 got ack=%b busy=%b exp 0 0", b1.ack, b1.busy); end
  endtask

  task automatic test_write();
    b1.ram_rdata = 32'h55AA55AA;
    b1.req = 1'b1; b1.rd = 1'b0; b1.wr = 1'b1; b1.addr = 32'h1FC00FFC;
    b1.be = 4'b0011; b1.wdata = 32'h12345678;
    tick();
    b1.req = 1'b0;
    checks++; if (b1.ram_cs !== 1'b1 || b1.ram_we !== 4'b0011 || b1.ram_addr !== 14'h03FF || b1.ram_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_c1 got cs=%b we=%b addr=%h wdata=%h exp 1 0011 03ff 12345678", b1.ram_cs, b1.ram_we, b1.ram_addr, b1.ram_wdata); end
    tick();
    checks++; if (b1.ram_we !== 4'h0 || b1.ack !== 1'b0) begin errors++; $display("FAIL wr_c2 got we=%h ack=%b exp 0 0", b1.ram_we, b1.ack); end
    tick();
    checks++; if (b1.ack !== 1'b1 || b1.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_c3 got ack=%b rdata=%h exp 1 deadbeef", b1.ack, b1.rdata); end
    tick();
    b1.ram_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_miss();
    logic [31:0] addrs [2];
    addrs[0] = 32'h1FC01000;
    addrs[1] = 32'h1FB00010;
    for (int i = 0; i < 2; i++) begin
      b1.req = 1'b1; b1.rd = 1'b1; b1.wr = 1'b0; b1.addr = addrs[i];
      tick();
      b1.req = 1'b0;
      checks++; if (b1.miss !== 1'b1 || b1.ram_cs !== 1'b0 || b1.busy !== 1'b0) begin errors++; $display("FAIL miss_%0d got miss=%b cs=%b busy=%b exp 1 0 0", i, b1.miss, b1.ram_cs, b1.busy); end
      tick();
      checks++; if (b1.miss !== 1'b0 || b1.ack !== 1'b0 || b1.ram_cs !== 1'b0) begin errors++; $display("FAIL miss_after_%0d got miss=%b ack=%b cs=%b exp 0 0 0", i, b1.miss, b1.ack, b1.ram_cs); end
      tick();
      checks++; if (b1.ack !== 1'b0) begin errors++; $display("FAIL miss_noack_%0d got ack=%b exp 0", i, b1.ack); end
    end
  endtask

  task automatic test_qualifiers();
    b1.req = 1'b1; b1.rd = 1'b1; b1.wr = 1'b1; b1.addr = 32'h1FC00010;
    tick();
    b1.req = 1'b0;
    checks++; if (b1.miss !== 1'b1 || b1.ram_cs !== 1'b0) begin errors++; $display("FAIL both_dir got miss=%b cs=%b exp 1 0", b1.miss, b1.ram_cs); end
    tick();
    b1.req = 1'b1; b1.rd = 1'b0; b1.wr = 1'b0;
    tick();
    b1.req = 1'b0;
    checks++; if (b1.miss !== 1'b0 || b1.ram_cs !== 1'b0 || b1.busy !== 1'b0 || b1.ack !== 1'b0) begin errors++; $display("FAIL no_dir got miss=%b cs=%b busy=%b ack=%b exp 0 0 0 0", b1.miss, b1.ram_cs, b1.busy, b1.ack); end
    tick();
  endtask

  task automatic test_back_to_back();
    b0.req = 1'b1; b0.rd = 1'b1; b0.wr = 1'b0; b0.addr = 32'h1FC00020;
    tick();  // cycle 1; req held high while busy
    checks++; if (b0.ram_cs !== 1'b1 || b0.ram_addr !== 14'h0008 || b0.busy !== 1'b1) begin errors++; $display("FAIL ws0_c1 got cs=%b addr=%h busy=%b exp 1 0008 1", b0.ram_cs, b0.ram_addr, b0.busy); end
    tick();  // cycle 2
    b0.req = 1'b0;
    checks++; if (b0.ack !== 1'b1 || b0.rdata !== 32'hCAFEF00D || b0.miss !== 1'b0 || b0.ram_cs !== 1'b0) begin errors++; $display("FAIL ws0_c2 got ack=%b rdata=%h miss=%b cs=%b exp 1 cafef00d 0 0", b0.ack, b0.rdata, b0.miss, b0.ram_cs); end
    tick();
    checks++; if (b0.ack !== 1'b0 || b0.miss !== 1'b0 || b0.ram_cs !== 1'b0 || b0.busy !== 1'b0) begin errors++; $display("FAIL ws0_c3 got ack=%b miss=%b cs=%b busy=%b exp 0 0 0 0", b0.ack, b0.miss, b0.ram_cs, b0.busy); end
    tick();
    checks++; if (b0.ram_cs !== 1'b0 || b0.ack !== 1'b0) begin errors++; $display("FAIL ws0_c4 got cs=%b ack=%b exp 0 0", b0.ram_cs, b0.ack); end
  endtask

  task automatic test_reset_abort();
    b1.req = 1'b1; b1.rd = 1'b1; b1.wr = 1'b0; b1.addr = 32'h1FC00010;
    b1.ram_rdata = 32'h0BADF00D;
    tick();
    b1.req = 1'b0;
    tick();  // WAIT
    checks++; if (b1.busy !== 1'b1 || b1.ack !== 1'b0) begin errors++; $display("FAIL abort_pre got busy=%b ack=%b exp 1 0", b1.busy, b1.ack); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (b1.busy !== 1'b0 || b1.ack !== 1'b0 || b1.miss !== 1'b0 || b1.ram_cs !== 1'b0 || b1.ram_we !== 4'h0) begin errors++; $display("FAIL abort_strobes got busy=%b ack=%b miss=%b cs=%b we=%h exp 0", b1.busy, b1.ack, b1.miss, b1.ram_cs, b1.ram_we); end
    checks++; if (b1.rdata !== 32'h0 || b1.ram_addr !== 14'h0 || b1.ram_wdata !== 32'h0) begin errors++; $display("FAIL abort_data got rdata=%h addr=%h wdata=%h exp 0", b1.rdata, b1.ram_addr, b1.ram_wdata); end
    tick(); tick();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (b1.ack !== 1'b0 || b1.ram_cs !== 1'b0 || b1.busy !== 1'b0) begin errors++; $display("FAIL abort_post_%0d got ack=%b cs=%b busy=%b exp 0 0 0", i, b1.ack, b1.ram_cs, b1.busy); end
    end
  endtask

  initial begin
    b1.req = 1'b0; b1.rd = 1'b0; b1.wr = 1'b0; b1.addr = '0; b1.be = '0; b1.wdata = '0;
    b1.base = 21'(32'h1FC00000 >> 11); b1.top = 12'h0FF; b1.ram_rdata = 32'hDEADBEEF;
    b0.req = 1'b0; b0.rd = 1'b0; b0.wr = 1'b0; b0.addr = '0; b0.be = '0; b0.wdata = '0;
    b0.base = 21'(32'h1FC00000 >> 11); b0.top = 12'h0FF; b0.ram_rdata = 32'hCAFEF00D;
    test_reset();
    test_read();
    test_write();
    test_miss();
    test_qualifiers();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
